// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel sequencer: FSM state enum,
// default geometry and the helper that sizes the row counter.
package pixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  localparam int DEF_RESOLUTION   = 8;
  localparam int DEF_ERASE_CYCLES = 5;
  localparam int MAX_ROWS         = 16;

  // Row counter is never narrower than one bit, even for a single-row array.
  function automatic int row_cnt_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/ramp_counter.sv
// Ramp/DAC code counter: counts up while enabled, clear has priority,
// tc flags the last code of the ramp (COUNT-1).
module ramp_counter #(
  parameter int WIDTH = 8,
  parameter int COUNT = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  assign count = count_q;
  assign tc    = (count_q == WIDTH'(COUNT - 1));

endmodule

// File: rtl/pixel_sequencer.sv
// Global-shutter frame sequencer: erase, expose, convert (ramp), row readout.
// Define PIXEL_SEQ_CONT_EN for back-to-back frames while start stays high.
module pixel_sequencer
  import pixel_pkg::*;
#(
  parameter int ROWS           = 2,
  parameter int ERASE_CYCLES   = DEF_ERASE_CYCLES,
  parameter int CONVERT_CYCLES = 256,
  parameter int RESOLUTION     = DEF_RESOLUTION
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           expose_len,
  output logic                  busy,
  output logic                  erase,
  output logic                  expose,
  output logic                  expose_clk,
  output logic                  convert,
  output logic [RESOLUTION-1:0] ramp_code,
  output logic [ROWS-1:0]       read_row,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  frame_done,
  output seq_state_t            dbg_state
);

  localparam int              ROW_W      = row_cnt_w(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [15:0]     ERASE_LAST = 16'(ERASE_CYCLES - 1);

  // Handshake: a row transfers on any cycle where rd_valid && rd_ready;
  // rd_valid never drops and read_row never changes until that happens.

  seq_state_t       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      exp_len_q, exp_len_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             clk_en_q;
  logic             ramp_en;
  logic             ramp_clr;
  logic             ramp_tc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      exp_len_q <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_len_q <= exp_len_d;
      row_q     <= row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_len_d = exp_len_q;
    row_d     = row_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_len_d = expose_len;
          cnt_d     = '0;
          state_d   = ST_ERASE;
        end
      end
      ST_ERASE: begin
        if (cnt_q == ERASE_LAST) begin
          cnt_d   = '0;
          state_d = (exp_len_q == 16'd0) ? ST_CONVERT : ST_EXPOSE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_EXPOSE: begin
        if (cnt_q == exp_len_q - 16'd1) begin
          cnt_d   = '0;
          state_d = ST_CONVERT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CONVERT: begin
        if (ramp_tc) begin
          row_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_ready) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = ST_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
`ifdef PIXEL_SEQ_CONT_EN
        // Holding start through frame_done chains the next frame.
        if (start) begin
          exp_len_d = expose_len;
          cnt_d     = '0;
          state_d   = ST_ERASE;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    erase      = 1'b0;
    expose     = 1'b0;
    convert    = 1'b0;
    rd_valid   = 1'b0;
    read_row   = '0;
    frame_done = 1'b0;
    ramp_en    = 1'b0;
    case (state_q)
      ST_ERASE:   erase = 1'b1;
      ST_EXPOSE:  expose = 1'b1;
      ST_CONVERT: begin
        convert = 1'b1;
        ramp_en = 1'b1;
      end
      ST_READ: begin
        rd_valid = 1'b1;
        read_row = ROWS'(1) << row_q;
      end
      ST_DONE:    frame_done = 1'b1;
      default:    ;
    endcase
  end

  assign ramp_clr  = !ramp_en || ramp_tc;
  assign dbg_state = state_q;

  ramp_counter #(
    .WIDTH (RESOLUTION),
    .COUNT (CONVERT_CYCLES)
  ) u_ramp (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ramp_clr),
    .en      (ramp_en),
    .count   (ramp_code),
    .tc      (ramp_tc)
  );

  // Enable changes only while clk is low, so the gated clock cannot glitch.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) clk_en_q <= 1'b0;
    else          clk_en_q <= expose;
  end

  assign expose_clk = clk & clk_en_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer: table of frames, random frames,
// mid-convert reset and (with PIXEL_SEQ_CONT_EN) chained frames.
module tb_pixel_sequencer;
  import pixel_pkg::*;

  localparam int ROWS   = 2;
  localparam int E      = 5;
  localparam int C      = 256;
  localparam int RES    = 8;
  localparam int BUDGET = 3000;
  localparam int VW     = 6 + ROWS + RES;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            rd_ready = 1'b0;
  logic [15:0]     expose_len = '0;
  logic            busy, erase, expose, expose_clk, convert, rd_valid, frame_done;
  logic [RES-1:0]  ramp_code;
  logic [ROWS-1:0] read_row;
  seq_state_t      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  typedef struct {
    int len;
    int stall0;
    int exp_lat;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;
  always @(posedge expose_clk) edges++;

  pixel_sequencer #(
    .ROWS(ROWS), .ERASE_CYCLES(E), .CONVERT_CYCLES(C), .RESOLUTION(RES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .expose_len(expose_len),
    .busy(busy), .erase(erase), .expose(expose), .expose_clk(expose_clk),
    .convert(convert), .ramp_code(ramp_code), .read_row(read_row),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  function automatic logic [VW-1:0] pack_out();
    return {busy, erase, expose, convert, rd_valid, frame_done, read_row, ramp_code};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected outputs come from the frame timeline: erase 1..E, expose next
  // len cycles, convert next C cycles with ramp = offset, then one row per
  // accepted handshake, then one frame_done cycle.
  task automatic run_frame(input int len, input bit rnd, input int stall0,
                           input bit chain_in, input bit chain_out,
                           input int next_len, output int done_k);
    int rows_acc, rc, edges0;
    bit in_read, done_now, e_er, e_ex, e_cv, e_rv;
    logic [ROWS-1:0] e_row;
    logic [RES-1:0]  e_ramp;
    logic [VW-1:0]   exp_v;
    rows_acc = 0;
    rc       = 0;
    done_k   = -1;
    edges0   = edges;
    if (!chain_in) begin
      @(posedge clk); #1;
      start      = 1'b1;
      expose_len = 16'(len);
      rd_ready   = 1'b0;
    end
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      in_read  = (k > E + len + C);
      done_now = in_read && (rows_acc == ROWS);
      e_er     = (k >= 1) && (k <= E);
      e_ex     = (k > E) && (k <= E + len);
      e_cv     = (k > E + len) && (k <= E + len + C);
      e_rv     = in_read && (rows_acc < ROWS);
      e_ramp   = e_cv ? RES'(k - E - len - 1) : '0;
      e_row    = e_rv ? (ROWS'(1) << rows_acc) : '0;
      exp_v    = {1'b1, e_er, e_ex, e_cv, e_rv, done_now, e_row, e_ramp};
      start      = 1'($urandom_range(0, 1));
      expose_len = 16'($urandom);
`ifdef PIXEL_SEQ_CONT_EN
      if (done_now) begin
        start      = chain_out;
        expose_len = 16'(next_len);
      end
`endif
      rd_ready = rnd ? ($urandom_range(0, 3) != 0) : (rc >= stall0);
      @(negedge clk);
      check($sformatf("cycle%0d_len%0d", k, len), 64'(pack_out()), 64'(exp_v));
      if (e_rv) begin
        rc++;
        if (rd_ready) rows_acc++;
      end
      if (done_now) begin
        done_k = k;
        break;
      end
    end
    check("frame_done_seen", 64'(done_k >= 0), 64'd1);
    check($sformatf("expose_clk_edges_len%0d", len), 64'(edges - edges0), 64'(len));
    if (!chain_out) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("idle_after_frame", 64'(pack_out()), 64'd0);
    end
  endtask

  initial begin
    int d;
    bit found;
    tbl[0] = '{len: 10, stall0: 0, exp_lat: 274};
    tbl[1] = '{len: 0,  stall0: 0, exp_lat: 264};
    tbl[2] = '{len: 10, stall0: 7, exp_lat: 281};
    tbl[3] = '{len: 1,  stall0: 0, exp_lat: 265};
    tbl[4] = '{len: 3,  stall0: 2, exp_lat: 269};

    #12;
    check("reset_outputs", 64'({pack_out(), expose_clk}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].len, 1'b0, tbl[i].stall0, 1'b0, 1'b0, 0, d);
      check($sformatf("latency_vec%0d", i), 64'(d), 64'(tbl[i].exp_lat));
    end

    for (int i = 0; i < 6; i++) begin
      run_frame(int'($urandom_range(0, 20)), 1'b1, 0, 1'b0, 1'b0, 0, d);
    end

    // Asynchronous reset while the ramp is mid-way.
    @(posedge clk); #1;
    start      = 1'b1;
    expose_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (convert && ramp_code == RES'(100)) begin
        found = 1'b1;
        break;
      end
    end
    check("ramp_reaches_100", 64'(found), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_clear_outputs", 64'(pack_out()), 64'd0);
    check("async_clear_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_frame(7, 1'b0, 0, 1'b0, 1'b0, 0, d);
    check("post_reset_latency", 64'(d), 64'd271);

`ifdef PIXEL_SEQ_CONT_EN
    run_frame(10, 1'b0, 0, 1'b0, 1'b1, 3, d);
    check("cont_first_latency", 64'(d), 64'd274);
    run_frame(3, 1'b0, 0, 1'b1, 1'b0, 0, d);
    check("cont_second_latency", 64'(d), 64'd267);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
